// File: rtl/mem_bus_responder.sv
// Memory-side responder for the sequencer operand/result bus.
// Serves one read or write at a time from an internal word memory after
// WAIT_CYCLES wait states, then returns a single-cycle next_state pulse.
// After completion it parks in HOLD until both request levels drop, so a
// request that is still held never produces a second completion.

module mem_bus_responder #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_AW      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_q,
  input  logic              write_q,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              next_state,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam int         MEM_DEPTH = 1 << MEM_AW;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                is_wr_q, is_wr_d;
  logic                both_q, both_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                ns_q, ns_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;

  // Memory contents survive reset, so the array carries no reset term.
  logic [DATA_W-1:0]   mem_q [MEM_DEPTH];
  logic                mem_we_s;
  logic [MEM_AW-1:0]   mem_idx_s;
  logic [DATA_W-1:0]   rdata_s;
  logic                oor_s;

  // Decode the latched address: any bit above the memory index means out of range.
  always_comb begin
    oor_s     = ((addr_q >> MEM_AW) != {ADDR_W{1'b0}});
    mem_idx_s = addr_q[MEM_AW-1:0];
    rdata_s   = mem_q[mem_idx_s];
  end

  // Next-state and output computation for the request/wait/ack/hold handshake.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    is_wr_d  = is_wr_q;
    both_d   = both_q;
    dout_d   = dout_q;
    ns_d     = 1'b0;
    err_d    = 1'b0;
    mem_we_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (read_q || write_q) begin
          // Write wins when both are raised; the conflict is flagged at ACK.
          addr_d  = addr;
          wdata_d = data_in;
          is_wr_d = write_q;
          both_d  = read_q & write_q;
          cnt_d   = WAIT_INIT;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Request levels are not looked at here; only latched values count.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_ACK;
          ns_d    = 1'b1;
          err_d   = both_q | oor_s;
          if (is_wr_q) begin
            mem_we_s = ~oor_s;
          end else begin
            dout_d = oor_s ? {DATA_W{1'b0}} : rdata_s;
          end
        end
      end
      ST_ACK: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!read_q && !write_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Control and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {DATA_W{1'b0}};
      is_wr_q <= 1'b0;
      both_q  <= 1'b0;
      dout_q  <= {DATA_W{1'b0}};
      ns_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      both_q  <= both_d;
      dout_q  <= dout_d;
      ns_q    <= ns_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Word memory write port, enabled only on an in-range write completion.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_idx_s] <= wdata_q;
    end
  end

  assign data_out   = dout_q;
  assign next_state = ns_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder with three instances (WAIT_CYCLES
// 2, 0 and 15). Each access pushes its expected result onto a scoreboard
// queue; the entry is popped and compared when next_state pulses.

module tb_mem_bus_responder;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_v  [3];
  logic        rd_v   [3];
  logic        wr_v   [3];
  logic [31:0] addr_v [3];
  logic [31:0] din_v  [3];

  logic [31:0] dout0, dout1, dout2;
  logic        ns0, ns1, ns2;
  logic        busy0, busy1, busy2;
  logic        err0, err1, err2;

  logic [31:0] o_dout;
  logic        o_ns, o_busy, o_err;

  int          checks   = 0;
  int          failures = 0;
  exp_t        sb [$];
  logic [31:0] mdl    [3][256];
  logic [31:0] dout_m [3];

  always #5 clk = ~clk;

  mem_bus_responder #(.DATA_W(32), .ADDR_W(32), .MEM_AW(8), .WAIT_CYCLES(2)) u_main (
    .clk(clk), .rst(rst_v[0]), .read_q(rd_v[0]), .write_q(wr_v[0]),
    .addr(addr_v[0]), .data_in(din_v[0]), .data_out(dout0),
    .next_state(ns0), .busy(busy0), .err(err0));

  mem_bus_responder #(.DATA_W(32), .ADDR_W(32), .MEM_AW(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst_v[1]), .read_q(rd_v[1]), .write_q(wr_v[1]),
    .addr(addr_v[1]), .data_in(din_v[1]), .data_out(dout1),
    .next_state(ns1), .busy(busy1), .err(err1));

  mem_bus_responder #(.DATA_W(32), .ADDR_W(32), .MEM_AW(8), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .rst(rst_v[2]), .read_q(rd_v[2]), .write_q(wr_v[2]),
    .addr(addr_v[2]), .data_in(din_v[2]), .data_out(dout2),
    .next_state(ns2), .busy(busy2), .err(err2));

  function automatic int wait_of(input int idx);
    case (idx)
      0:       return 2;
      1:       return 0;
      default: return 15;
    endcase
  endfunction

  task automatic get(input int idx);
    case (idx)
      0:       begin o_dout = dout0; o_ns = ns0; o_busy = busy0; o_err = err0; end
      1:       begin o_dout = dout1; o_ns = ns1; o_busy = busy1; o_err = err1; end
      default: begin o_dout = dout2; o_ns = ns2; o_busy = busy2; o_err = err2; end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access: drive, wait for the pulse, compare, release.
  task automatic xact(input int idx, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] d,
                      input int hold, input bit drop_early);
    exp_t e;
    exp_t got;
    bit   oor;
    bit   seen;
    int   n;
    oor   = (a >= 32'd256);
    e.err = (rd && wr) || oor;
    e.lat = wait_of(idx) + 1;
    if (wr) begin
      if (!oor) mdl[idx][a[7:0]] = d;
    end else begin
      dout_m[idx] = oor ? 32'd0 : mdl[idx][a[7:0]];
    end
    e.data = dout_m[idx];

    @(negedge clk);
    rd_v[idx] = rd; wr_v[idx] = wr; addr_v[idx] = a; din_v[idx] = d;
    sb.push_back(e);
    @(posedge clk);
    if (drop_early) begin
      #1; rd_v[idx] = 1'b0; wr_v[idx] = 1'b0;
    end
    n = 0; seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      get(idx);
      if (o_ns) seen = 1'b1;
    end
    if (!seen) begin
      chk("ack_timeout", 32'd0, 32'd1);
      sb.delete();
    end else if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk("latency", n, got.lat);
      chk("data_out", o_dout, got.data);
      chk("err", {31'd0, o_err}, {31'd0, got.err});
      chk("busy_ack", {31'd0, o_busy}, 32'd1);
      @(posedge clk); #1; get(idx);
      chk("pulse_width", {30'd0, o_ns, o_err}, 32'd0);
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1; get(idx);
        chk("hold_no_repeat", {30'd0, o_ns, o_busy}, 32'd1);
      end
    end
    @(negedge clk);
    rd_v[idx] = 1'b0; wr_v[idx] = 1'b0;
    @(posedge clk); #1; get(idx);
    chk("idle_busy", {31'd0, o_busy}, 32'd0);
    chk("data_hold", o_dout, dout_m[idx]);
  endtask

  // Start a write, then assert reset one edge into BUSY.
  task automatic abort_write(input int idx, input logic [31:0] a, input logic [31:0] d);
    logic any_ns;
    @(negedge clk);
    wr_v[idx] = 1'b1; addr_v[idx] = a; din_v[idx] = d;
    @(posedge clk);
    @(posedge clk);
    #2; rst_v[idx] = 1'b0;
    #1; get(idx);
    dout_m[idx] = 32'd0;
    chk("abort_dout", o_dout, 32'd0);
    chk("abort_flags", {29'd0, o_ns, o_busy, o_err}, 32'd0);
    @(negedge clk); wr_v[idx] = 1'b0;
    @(negedge clk); rst_v[idx] = 1'b1;
    any_ns = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1; get(idx);
      any_ns = any_ns | o_ns;
    end
    chk("abort_no_pulse", {31'd0, any_ns}, 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_v[k] = 1'b0; rd_v[k] = 1'b0; wr_v[k] = 1'b0;
      addr_v[k] = 32'd0; din_v[k] = 32'd0; dout_m[k] = 32'd0;
      for (int j = 0; j < 256; j++) mdl[k][j] = 32'd0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      get(k);
      chk("rst_dout", o_dout, 32'd0);
      chk("rst_flags", {29'd0, o_ns, o_busy, o_err}, 32'd0);
    end
    for (int k = 0; k < 3; k++) rst_v[k] = 1'b1;
    @(negedge clk);

    // Write then readback with a held request; a write leaves data_out alone.
    xact(0, 1'b0, 1'b1, 32'd5, 32'hDEADBEEF, 0, 1'b0);
    xact(0, 1'b1, 1'b0, 32'd5, 32'd0, 5, 1'b0);
    xact(0, 1'b0, 1'b1, 32'd6, 32'hCAFEF00D, 0, 1'b0);
    // Request dropped during BUSY still completes.
    xact(0, 1'b1, 1'b0, 32'd6, 32'd0, 0, 1'b1);

    // Latency extremes.
    xact(1, 1'b0, 1'b1, 32'd0, 32'h00000001, 0, 1'b0);
    xact(1, 1'b1, 1'b0, 32'd0, 32'd0, 0, 1'b0);
    xact(2, 1'b0, 1'b1, 32'd0, 32'h00000002, 0, 1'b0);
    xact(2, 1'b1, 1'b0, 32'd0, 32'd0, 2, 1'b0);

    // Out-of-range accesses must not alias onto word 0.
    xact(0, 1'b0, 1'b1, 32'd0, 32'h12345678, 0, 1'b0);
    xact(0, 1'b0, 1'b1, 32'h100, 32'h55, 0, 1'b0);
    xact(0, 1'b1, 1'b0, 32'h100, 32'd0, 0, 1'b0);
    xact(0, 1'b1, 1'b0, 32'd0, 32'd0, 0, 1'b0);

    // Both requests: write wins with err, then a clean read.
    xact(0, 1'b1, 1'b1, 32'd7, 32'hA5, 0, 1'b0);
    xact(0, 1'b1, 1'b0, 32'd7, 32'd0, 0, 1'b0);

    // Reset mid-BUSY must leave the old word in place.
    xact(0, 1'b0, 1'b1, 32'd9, 32'h99, 0, 1'b0);
    abort_write(0, 32'd9, 32'h77);
    xact(0, 1'b1, 1'b0, 32'd9, 32'd0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
